// File: rtl/bitmap_pkg.sv
// Shared types and helpers for the bitmap encoder and related bitmap blocks.
package bitmap_pkg;

  typedef enum logic {IDLE, DRAIN} enc_state_t;

  // Helper operand width; covers bitmaps up to WIDTH = 8.
  localparam int MAX_N = 256;

  function automatic logic onehot_count_is_one(input logic [MAX_N-1:0] vector);
    return (vector != '0) && ((vector & (vector - MAX_N'(1))) == '0);
  endfunction

endpackage

// File: rtl/bitmap_encoder_prio_enc.sv
// Combinational priority encoder: index of the lowest (LSB_FIRST=1) or highest set bit.
module prio_enc #(
  parameter int WIDTH     = 3,
  parameter bit LSB_FIRST = 1'b1,
  localparam int N        = 1 << WIDTH
) (
  input  logic [N-1:0]     vector,
  output logic [WIDTH-1:0] index,
  output logic             any
);

  always_comb begin
    index = '0;
    any   = |vector;
    // Scan away from the winning end so the preferred bit is written last.
    if (LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--)
        if (vector[i]) index = WIDTH'(i);
    end else begin
      for (int i = 0; i < N; i++)
        if (vector[i]) index = WIDTH'(i);
    end
  end

endmodule

// File: rtl/bitmap_encoder.sv
// Bitmap-to-index stream encoder: emits one index per set bit, in priority order.
module bitmap_encoder
  import bitmap_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter bit LSB_FIRST = 1'b1,
  localparam int N        = 1 << WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vector,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_index,
  output logic             out_last
);

  enc_state_t       state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic             pend_any;
  logic             fire_out, accept;

  prio_enc #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_prio (
    .vector (pending_q),
    .index  (out_index),
    .any    (pend_any)
  );

  assign out_valid = (state_q == DRAIN);
  assign out_last  = onehot_count_is_one(MAX_N'(pending_q));
  assign fire_out  = out_valid && out_ready;
  assign in_ready  = (state_q == IDLE) || (fire_out && out_last);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (fire_out) begin
      pending_d = pending_q & ~(N'(1) << out_index);
      if (out_last) state_d = IDLE;
    end
    // An all-zero bitmap is swallowed; pending is already empty whenever in_ready is high.
    if (accept && (in_vector != '0)) begin
      pending_d = in_vector;
      state_d   = DRAIN;
    end
    // Never sit in DRAIN with nothing to emit.
    if ((state_d == DRAIN) && (pending_d == '0)) state_d = IDLE;
    if ((state_q == DRAIN) && !pend_any)         state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule
